bus_arbiter_rr: RTL
===================

Name: bus_arbiter_rr

Overview:
- Round-robin arbiter that shares the single CPU memory bus (addr/wdata/wmask/ren/wen/rdata/done) between NUM_MASTERS requesters.
- Typical masters: the pipelined core's data port, an instruction-cache refill engine and a DMA engine.
- Sits between the masters and the memory/peripheral interconnect.
- Holds the grant for a whole transaction, and provides a watchdog timeout so a hung slave cannot deadlock the system.

Parameters:
- NUM_MASTERS, 2, number of requesting ports (2..8).
- TIMEOUT_CYCLES, 256, cycles a granted transaction may wait for s_done before forced completion; 0 disables the watchdog.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- m_addr  input  32*NUM_MASTERS  per-master byte address, packed, master i at [32*i+:32].
- m_wdata  input  32*NUM_MASTERS  per-master write data, packed.
- m_wmask  input  4*NUM_MASTERS  per-master byte write mask, packed.
- m_ren  input  NUM_MASTERS  per-master read request.
- m_wen  input  NUM_MASTERS  per-master write request.
- m_rdata  output  32  read data, broadcast to all masters.
- m_done  output  NUM_MASTERS  per-master completion pulse.
- s_addr  output  32  to slave.
- s_wdata  output  32  to slave.
- s_wmask  output  4  to slave.
- s_ren  output  1  to slave.
- s_wen  output  1  to slave.
- s_rdata  input  32  from slave.
- s_done  input  1  from slave.
- grant  output  NUM_MASTERS  one-hot current owner; all-zero when idle.
- timeout_err  output  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Master protocol:
  - Master i requests with req_i = m_ren[i] | m_wen[i].
  - Address, data and mask stay stable until m_done[i].
  - m_rdata is valid only in the m_done[i] cycle.
- States are IDLE and BUSY. A registered grant register plus an owner index drive the mux.
- IDLE:
  - All s_* outputs are 0 and grant=0.
  - At a clock edge with any req, pick the winner by round-robin: search starts at (last_owner+1) mod NUM_MASTERS and takes the first requesting index.
  - Load grant and owner, set last_owner=winner, go to BUSY.
  - Arbitration latency: request visible at edge t, so s_ren/s_wen are asserted from cycle t+1.
- BUSY:
  - s_addr, s_wdata and s_wmask come combinationally from the owner.
  - s_ren = m_ren[owner] & ~m_wen[owner]; s_wen = m_wen[owner]. When both are set, the write wins.
  - m_done[owner] = s_done, combinationally. All other m_done bits are 0.
  - m_rdata = s_rdata in every state.
- BUSY exits:
  - s_done=1 at an edge: go to IDLE. This gives one mandatory bubble cycle between transactions, so the same master can win again only if no other master is requesting.
  - Owner drops req without s_done (abort): go to IDLE next edge, with no m_done and no error.
  - Watchdog (TIMEOUT_CYCLES>0):
    - A counter clears on entry to BUSY and increments each BUSY cycle without s_done.
    - When it reaches TIMEOUT_CYCLES-1, in that cycle: drive m_done[owner]=1, m_rdata=0, s_ren=s_wen=0, timeout_err=1.
    - Then go to IDLE at the next edge.
    - s_done in that same cycle takes priority: normal completion, no error.
- Fairness: a continuously requesting master waits at most NUM_MASTERS-1 transactions.
- Reset:
  - Asynchronous. State=IDLE, grant=0, owner=0, last_owner=NUM_MASTERS-1 (so master 0 wins first), counter=0, timeout_err=0.
  - All s_* outputs and m_done are 0 immediately, even mid-transaction. The in-flight transaction is dropped without a done pulse.
- Widths: the counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates; owner is $clog2(NUM_MASTERS) bits, minimum 1.
- Grant only ever changes at a clock edge, never combinationally.

Decomposition:
- Package cpu_bus_pkg:
  - BUS_ADDR_W=32, BUS_DATA_W=32, BUS_MASK_W=4.
  - typedef enum arb_state_t {ARB_IDLE, ARB_BUSY}.
- Sub-module rr_priority_picker (combinational):
  - Inputs: req vector, last_owner.
  - Outputs: winner index, valid.
  - Reusable for future interrupt/DMA-channel arbitration.

Test Plan:
- Single master: m_ren[0]=1, m_addr0=0x100, slave returns 0xDEADBEEF with s_done after 3 cycles -> s_ren high from cycle 1, m_done[0] pulses once with m_rdata=0xDEADBEEF, grant back to 0 the next cycle.
- Contention: masters 0 and 1 request continuously, slave done in 1 cycle -> grant sequence 01,10,01,10 with one idle cycle between each, no master starved.
- Write priority: master 1 asserts m_wen and m_ren together with wmask=4'b0011, wdata=0x12345678 -> s_wen=1, s_ren=0, s_wmask=0011, s_wdata=0x12345678.
- Timeout: TIMEOUT_CYCLES=8, slave never responds -> in cycle 8 of BUSY, m_done=1, m_rdata=0 and timeout_err pulses for exactly one cycle; the next requester is then granted normally.
- Reset mid-transaction: assert rst during BUSY between clock edges -> s_ren, s_wen, grant and m_done go to 0 immediately; after release, master 0 wins first.
- Abort: master 0 granted, then drops m_ren before s_done -> IDLE next edge, no m_done pulse, timeout_err=0.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared CPU memory-bus widths, arbiter state encoding and index helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_MASK_W = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round-robin distance of index j from the slot just after last.
    // The slot right after last is 0; last itself is n-1, so it is considered last.
    function automatic int rr_dist(input int j, input int last, input int n);
        return (j - last - 1 + 2 * n) % n;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first requester at or after (last_owner+1) mod N.
// Latency: purely combinational.
// Backpressure: none; valid is low when nobody requests.
//
// Ports:
//   req        - request vector, one bit per requester
//   last_owner - index of the previous winner
//   winner     - selected index (0 when valid is low)
//   valid      - at least one request present
module rr_priority_picker
    import cpu_bus_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_owner,
    output logic [IW-1:0] winner,
    output logic          valid
);

    int best_dist;

    // Smallest rotated distance among requesters wins.
    always_comb begin
        winner    = '0;
        valid     = 1'b0;
        best_dist = N;
        for (int j = 0; j < N; j++) begin
            if (req[j] && (rr_dist(j, int'(last_owner), N) < best_dist)) begin
                best_dist = rr_dist(j, int'(last_owner), N);
                winner    = IW'(j);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter sharing one CPU memory bus between NUM_MASTERS masters.
// Latency: request seen at edge t drives s_ren/s_wen from cycle t+1; one idle bubble after each transaction.
// Backpressure: grant held until s_done, owner abort, or watchdog expiry.
//
// Ports: clk/rst (async active-high); m_* packed per-master request side
// (master i at [W*i +: W]); s_* single slave side; grant one-hot owner;
// timeout_err pulses in the cycle the watchdog forces completion.
module bus_arbiter_rr
    import cpu_bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [BUS_ADDR_W*NUM_MASTERS-1:0] m_addr,
    input  logic [BUS_DATA_W*NUM_MASTERS-1:0] m_wdata,
    input  logic [BUS_MASK_W*NUM_MASTERS-1:0] m_wmask,
    input  logic [NUM_MASTERS-1:0]            m_ren,
    input  logic [NUM_MASTERS-1:0]            m_wen,
    output logic [BUS_DATA_W-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]            m_done,
    output logic [BUS_ADDR_W-1:0]             s_addr,
    output logic [BUS_DATA_W-1:0]             s_wdata,
    output logic [BUS_MASK_W-1:0]             s_wmask,
    output logic                              s_ren,
    output logic                              s_wen,
    input  logic [BUS_DATA_W-1:0]             s_rdata,
    input  logic                              s_done,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic                              timeout_err
);

    localparam int            OW      = idx_w(NUM_MASTERS);
    localparam int            CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit            WD_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] CNT_EXP = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX = '1;

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic [OW-1:0]          last_q, last_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic [NUM_MASTERS-1:0] req;
    logic [OW-1:0]          pick_idx;
    logic                   pick_vld;
    logic                   busy;
    logic                   owner_req;
    logic                   wd_hit;

    assign req       = m_ren | m_wen;
    assign busy      = (state_q == ARB_BUSY);
    assign owner_req = req[owner_q];
    // An owner that has already dropped its request is an abort, not a timeout.
    assign wd_hit    = WD_EN && busy && owner_req && !s_done && (cnt_q == CNT_EXP);

    rr_priority_picker #(.N(NUM_MASTERS)) u_picker (
        .req        (req),
        .last_owner (last_q),
        .winner     (pick_idx),
        .valid      (pick_vld)
    );

    // Slave side: everything is gated by the registered state, so reset
    // silences the bus immediately even mid-transaction.
    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wmask = '0;
        s_ren   = 1'b0;
        s_wen   = 1'b0;
        m_done  = '0;
        if (busy) begin
            s_addr  = m_addr[BUS_ADDR_W*owner_q +: BUS_ADDR_W];
            s_wdata = m_wdata[BUS_DATA_W*owner_q +: BUS_DATA_W];
            s_wmask = m_wmask[BUS_MASK_W*owner_q +: BUS_MASK_W];
            // Write wins when a master raises both strobes.
            s_ren   = m_ren[owner_q] & ~m_wen[owner_q] & ~wd_hit;
            s_wen   = m_wen[owner_q] & ~wd_hit;
            m_done[owner_q] = s_done | wd_hit;
        end
    end

    assign m_rdata     = wd_hit ? '0 : s_rdata;
    assign grant       = grant_q;
    assign timeout_err = wd_hit;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_d = ARB_BUSY;
                    grant_d = NUM_MASTERS'(1) << pick_idx;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            ARB_BUSY: begin
                if (s_done || wd_hit || !owner_req) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= OW'(NUM_MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
